counter_load_sequencer: RTL and testbench

Upstream companion to the 4-bit loadable counter. It queues requested reload values and drives the counter's load strobe and load value. Reload values enter through a valid/ready handshake into a small FIFO. When the counter's current count equals a trigger value and a reload is queued, the block issues a single-cycle registered load pulse carrying the oldest queued value.

---
 rtl/counter_load_sequencer.sv | 121 ++++++++++++
 tb/tb_counter_load_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_load_sequencer.sv
// Reload sequencer for a 4-bit loadable counter: queues reload values in a small FIFO
// and issues a registered load pulse with the oldest value when count_i hits trig_val_i.
module counter_load_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_i,
  input  logic [3:0]               req_val_i,
  output logic                     req_ready_o,
  input  logic                     flush_i,
  input  logic [3:0]               trig_val_i,
  input  logic [3:0]               count_i,
  output logic                     load_o,
  output logic [3:0]               load_val_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_load;
  logic [3:0]      r_load_val;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_match;

  assign w_full      = (r_cnt == CW'(DEPTH));
  assign req_ready_o = !w_full && !flush_i;
  assign w_push      = req_valid_i && req_ready_o;
  assign w_match     = (count_i == trig_val_i);

  assign load_o     = r_load;
  assign load_val_o = r_load_val;
  assign fifo_cnt_o = r_cnt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = w_push  ? ST_ARMED : ST_IDLE;
        ST_ARMED: w_state_nxt = w_match ? ST_FIRE  : ST_ARMED;
        ST_FIRE:  w_state_nxt = (w_cnt_nxt != {CW{1'b0}}) ? ST_ARMED : ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pop decision and next occupancy; ARMED guarantees a non-empty FIFO
  always_comb begin
    w_pop     = 1'b0;
    w_cnt_nxt = r_cnt;
    if (!flush_i && (r_state == ST_ARMED) && w_match) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    if (flush_i) begin
      w_cnt_nxt = {CW{1'b0}};
    end else begin
      w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage, pointers and the registered load strobe/value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 4'h0;
      end
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_load     <= 1'b0;
      r_load_val <= 4'h0;
    end else if (flush_i) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_load   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= req_val_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_load_val <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + PW'(1);
      end
      r_load <= w_pop;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_counter_load_sequencer.sv
// Scoreboard bench for counter_load_sequencer: a queue-based reference model predicts
// load values; a negedge monitor compares every output against it.
module tb_counter_load_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_i;
  logic [3:0] req_val_i;
  logic       req_ready_o;
  logic       flush_i;
  logic [3:0] trig_val_i;
  logic [3:0] count_i;
  logic       load_o;
  logic [3:0] load_val_o;
  logic [2:0] fifo_cnt_o;

  logic       use_ctr;
  logic [3:0] count_rnd;
  logic [3:0] count_ctr = 4'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_load_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req_valid_i (req_valid_i),
    .req_val_i   (req_val_i),
    .req_ready_o (req_ready_o),
    .flush_i     (flush_i),
    .trig_val_i  (trig_val_i),
    .count_i     (count_i),
    .load_o      (load_o),
    .load_val_o  (load_val_o),
    .fifo_cnt_o  (fifo_cnt_o)
  );

  // Downstream 4-bit loadable counter
  always @(posedge clk) count_ctr <= load_o ? load_val_o : count_ctr + 4'd1;
  assign count_i = use_ctr ? count_ctr : count_rnd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending reloads plus "a pulse is in flight" flag
  logic [3:0] m_q[$];
  logic [3:0] sb[$];
  bit         m_fire;

  always @(posedge clk or negedge rst_n) begin : p_model
    bit acc;
    bit fire;
    if (!rst_n) begin
      m_q.delete();
      sb.delete();
      m_fire = 1'b0;
    end else if (flush_i) begin
      m_q.delete();
      m_fire = 1'b0;
    end else begin
      acc  = req_valid_i && (m_q.size() < DEPTH);
      fire = !m_fire && (m_q.size() > 0) && (count_i == trig_val_i);
      if (fire) sb.push_back(m_q.pop_front());
      if (acc)  m_q.push_back(req_val_i);
      m_fire = fire;
    end
  end

  // Monitor: compares outputs each negedge, pops scoreboard on every load pulse
  always @(negedge clk) begin
    check("fifo_cnt", fifo_cnt_o, m_q.size());
    check("req_ready", req_ready_o, (m_q.size() < DEPTH) && !flush_i);
    check("load_o", load_o, m_fire);
    if (load_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL load_val: pulse with value %0d but nothing expected (t=%0t)", load_val_o, $time);
      end else begin
        check("load_val", load_val_o, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [3:0] v);
    int n;
    n = 0;
    req_valid_i = 1'b1;
    req_val_i   = v;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: ready low for %0d cycles, required high", n);
    end
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_load(input int bound);
    int n;
    n = 0;
    while (load_o !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (load_o !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: load_o=%0b after %0d cycles, required 1", load_o, n);
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    trig_val_i = 4'h0;
    count_rnd  = 4'h0;
    while (fifo_cnt_o != 3'd0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_empty", fifo_cnt_o, 0);
    tick();
    tick();
    trig_val_i = 4'hF;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_val_i   = 4'h0;
    flush_i     = 1'b0;
    trig_val_i  = 4'h0;
    count_rnd   = 4'h0;
    use_ctr     = 1'b0;
    #12;
    check("rst_load", load_o, 0);
    check("rst_val", load_val_o, 0);
    check("rst_cnt", fifo_cnt_o, 0);
    check("rst_ready", req_ready_o, 1);
    rst_n = 1'b1;
    tick();

    // Single reload against the free-running counter
    use_ctr    = 1'b1;
    trig_val_i = 4'h5;
    push(4'h9);
    wait_load(40);
    check("t1_val", load_val_o, 9);
    @(negedge clk);
    check("t1_counter", count_ctr, 9);
    check("t1_cnt", fifo_cnt_o, 0);

    // Fill and backpressure
    use_ctr    = 1'b0;
    count_rnd  = 4'h0;
    trig_val_i = 4'hF;
    tick();
    for (int i = 1; i <= 4; i++) push(4'(i));
    check("fill_cnt", fifo_cnt_o, 4);
    check("fill_ready", req_ready_o, 0);
    req_valid_i = 1'b1;
    req_val_i   = 4'h5;
    repeat (3) tick();
    check("full_held", fifo_cnt_o, 4);
    trig_val_i = 4'h0;
    push(4'h5);
    drain(60);

    // Simultaneous push and pop
    push(4'h6);
    push(4'h7);
    check("pp_pre", fifo_cnt_o, 2);
    req_valid_i = 1'b1;
    req_val_i   = 4'h8;
    trig_val_i  = 4'h0;
    tick();
    req_valid_i = 1'b0;
    trig_val_i  = 4'hF;
    check("pp_cnt", fifo_cnt_o, 2);
    check("pp_load", load_o, 1);
    drain(60);

    // Self-retrigger spacing
    push(4'h3);
    push(4'h3);
    trig_val_i = 4'h3;
    use_ctr    = 1'b1;
    wait_load(40);
    @(negedge clk);
    check("retrig_gap", load_o, 0);
    @(negedge clk);
    check("retrig_second", load_o, 1);
    check("retrig_val", load_val_o, 3);
    tick();
    use_ctr    = 1'b0;
    trig_val_i = 4'hF;
    tick();

    // Flush in ARMED with three entries, plus a request during the flush cycle
    push(4'h1);
    push(4'h2);
    push(4'h3);
    check("fl_pre", fifo_cnt_o, 3);
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    req_val_i   = 4'hA;
    tick();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    check("fl_cnt", fifo_cnt_o, 0);
    trig_val_i = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fl_noload", load_o, 0);
    end
    tick();

    // Randomised traffic: wrap-around, push/pop overlap, occasional flush
    for (int c = 0; c < 600; c++) begin
      req_valid_i = 1'($urandom_range(0, 1));
      req_val_i   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) trig_val_i = 4'($urandom_range(0, 15));
      count_rnd = ($urandom_range(0, 2) == 0) ? trig_val_i : 4'($urandom_range(0, 15));
      flush_i   = ($urandom_range(0, 40) == 0);
      tick();
    end
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    trig_val_i  = 4'hF;
    count_rnd   = 4'h0;
    tick();

    // Reset asserted while a load pulse is high
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    push(4'hC);
    trig_val_i = 4'h0;
    wait_load(20);
    #1 rst_n = 1'b0;
    #1;
    check("rstp_load", load_o, 0);
    check("rstp_val", load_val_o, 0);
    check("rstp_cnt", fifo_cnt_o, 0);
    check("rstp_ready", req_ready_o, 1);
    #2 rst_n = 1'b1;
    trig_val_i = 4'hF;
    repeat (3) tick();

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
